alu_issuer: RTL and testbench

Command-side front end for the 16-bit ALU: accepts one operation (opcode, A, B) per valid/ready handshake and drives it onto the ALU operand/opcode inputs. It waits a fixed, parameterised ALU latency, captures the ALU result (Y, carry), and returns it on a valid/ready response channel. It sits between the controller/host logic and the ALU, so upstream logic never has to track ALU pipeline depth.

---
 rtl/alu_issuer.sv | 103 ++++++++++
 tb/tb_alu_issuer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issuer.sv
// rtl/alu_issuer.sv - single-issue front end that hands one operation to the ALU and returns its result
// Hides ALU pipeline depth from upstream: one op in flight, result held until the consumer takes it.
module alu_issuer #(
   parameter int nbits = 15,
   parameter int lat   = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [nbits:0]   cmd_a,
   input  logic [nbits:0]   cmd_b,
   output logic [nbits:0]   alu_a,
   output logic [nbits:0]   alu_b,
   output logic [2:0]       alu_opcode,
   input  logic [nbits+1:0] alu_y,
   input  logic             alu_co,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [nbits+1:0] rsp_y,
   output logic             rsp_co,
   output logic [2:0]       rsp_op,
   output logic             busy,
   output logic [15:0]      op_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [2:0] LAT_LOAD = 3'(lat);

   state_t     state;
   logic [2:0] cnt;
   logic [2:0] op_q;

   // cmd_ready and busy are registered alongside state, so they never see cmd_valid or rsp_ready.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= 3'd0;
         op_q       <= 3'd0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_opcode <= 3'd0;
         rsp_valid  <= 1'b0;
         rsp_y      <= '0;
         rsp_co     <= 1'b0;
         rsp_op     <= 3'd0;
         op_count   <= 16'd0;
         cmd_ready  <= 1'b1;
         busy       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  alu_a      <= cmd_a;
                  alu_b      <= cmd_b;
                  alu_opcode <= cmd_op;
                  op_q       <= cmd_op;
                  cnt        <= LAT_LOAD;
                  state      <= WAIT;
                  cmd_ready  <= 1'b0;
                  busy       <= 1'b1;
               end
            end
            WAIT: begin
               // Capture on the edge where the counter reaches one: exactly lat edges after accept.
               if (cnt > 3'd1) begin
                  cnt <= cnt - 3'd1;
               end else begin
                  cnt       <= 3'd0;
                  rsp_y     <= alu_y;
                  rsp_co    <= alu_co;
                  rsp_op    <= op_q;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  op_count  <= op_count + 16'd1;
                  state     <= IDLE;
                  cmd_ready <= 1'b1;
                  busy      <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               cnt       <= 3'd0;
               rsp_valid <= 1'b0;
               cmd_ready <= 1'b1;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issuer.sv
// tb/tb_alu_issuer.sv - randomized and directed bench for alu_issuer against a timing-level reference model
module tb_alu_issuer;

   localparam int NBITS = 15;
   localparam int LAT   = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_op;
   logic [15:0] cmd_a, cmd_b;
   logic [15:0] alu_a, alu_b;
   logic [2:0]  alu_opcode;
   logic [16:0] alu_y;
   logic        alu_co;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [16:0] rsp_y;
   logic        rsp_co;
   logic [2:0]  rsp_op;
   logic        busy;
   logic [15:0] op_count;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   alu_issuer #(.nbits(NBITS), .lat(LAT)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_a(cmd_a), .cmd_b(cmd_b),
      .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
      .alu_y(alu_y), .alu_co(alu_co),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_y(rsp_y), .rsp_co(rsp_co), .rsp_op(rsp_op),
      .busy(busy), .op_count(op_count)
   );

   function automatic logic [17:0] alu_f(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
      logic [16:0] y;
      case (op)
         3'd0:    y = {1'b0, a} + {1'b0, b};
         3'd4:    y = {1'b0, a};
         default: y = {1'b0, a ^ b};
      endcase
      return {(op == 3'd0) ? y[16] : 1'b0, y};
   endfunction

   // ALU stub: combinational function followed by LAT-1 registers, so Y is valid for the edge E0+LAT.
   logic [17:0] pipe [LAT-1];
   always @(posedge clk) begin
      pipe[0] <= alu_f(alu_opcode, alu_a, alu_b);
      for (int i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
   end
   assign alu_y  = pipe[LAT-2][16:0];
   assign alu_co = pipe[LAT-2][17];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // Reference model: one op in flight, described by its accept edge number and expected result.
   int          cyc = 0;
   bit          m_busy;
   int          t_acc;
   logic [17:0] m_exp;
   logic [15:0] m_a, m_b;
   logic [2:0]  m_op;
   logic [16:0] m_ry;
   logic        m_rco;
   logic [2:0]  m_rop;
   logic [15:0] m_count;
   int          n_acc = 0;
   int          acc_cyc[$];

   function automatic bit m_valid();
      return m_busy && (cyc >= t_acc + LAT);
   endfunction

   task automatic model_step();
      if (rst) begin
         m_busy = 0; t_acc = 0;
         m_a = '0; m_b = '0; m_op = '0;
         m_ry = '0; m_rco = 1'b0; m_rop = '0;
         m_count = '0;
      end else if (!m_busy) begin
         if (cmd_valid) begin
            m_busy = 1;
            t_acc  = cyc + 1;
            m_a = cmd_a; m_b = cmd_b; m_op = cmd_op;
            m_exp = alu_f(cmd_op, cmd_a, cmd_b);
            n_acc++;
            acc_cyc.push_back(cyc + 1);
         end
      end else if (m_valid()) begin
         if (rsp_ready) begin
            m_busy  = 0;
            m_count = m_count + 16'd1;
         end
      end else if (cyc + 1 == t_acc + LAT) begin
         {m_rco, m_ry} = m_exp;
         m_rop = m_op;
      end
      cyc++;
   endtask

   task automatic compare();
      check("cmd_ready",  cmd_ready,  !m_busy);
      check("busy",       busy,       m_busy);
      check("rsp_valid",  rsp_valid,  m_valid());
      check("op_count",   op_count,   m_count);
      check("alu_a",      alu_a,      m_a);
      check("alu_b",      alu_b,      m_b);
      check("alu_opcode", alu_opcode, m_op);
      check("rsp_y",      rsp_y,      m_ry);
      check("rsp_co",     rsp_co,     m_rco);
      check("rsp_op",     rsp_op,     m_rop);
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      @(negedge clk);
      compare();
   endtask

   task automatic send(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
      int n0;
      n0 = n_acc;
      cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
      for (int k = 0; k < 40 && n_acc == n0; k++) tick();
      if (n_acc == n0) check("accept_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 40 && m_busy; k++) tick();
      if (m_busy) check("drain_timeout", 32'd0, 32'd1);
   endtask

   int  n0, i0;
   bit  saw_valid;

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b0;
      tick(); tick();
      rst = 1'b0;
      tick();
      check("reset_ready", cmd_ready, 1'b1);
      check("reset_count", op_count, 16'd0);

      // single add
      rsp_ready = 1'b1;
      send(3'd0, 16'h0003, 16'h0004);
      check("add_alu_a", alu_a, 16'h0003);
      drain();
      check("add_rsp_y", rsp_y, 17'h00007);
      check("add_count", op_count, 16'd1);

      // carry with back-pressure while a second command waits
      rsp_ready = 1'b0;
      send(3'd0, 16'hFFFF, 16'h0001);
      n0 = n_acc;
      cmd_valid = 1'b1; cmd_op = 3'd4; cmd_a = 16'h0055; cmd_b = 16'h0000;
      for (int k = 0; k < LAT + 5; k++) tick();
      check("carry_rsp_y", rsp_y, 17'h10000);
      check("carry_rsp_co", rsp_co, 1'b1);
      check("held_not_accepted", n_acc, n0);
      rsp_ready = 1'b1;
      for (int k = 0; k < 10 && n_acc == n0; k++) tick();
      check("held_accepted", n_acc, n0 + 1);
      check("held_accept_gap", acc_cyc[$] - acc_cyc[$-1], LAT + 5 + 2);
      cmd_valid = 1'b0;
      drain();

      // back-to-back
      n0 = op_count;
      i0 = acc_cyc.size();
      send(3'd4, 16'h1234, 16'h0000);
      send(3'd0, 16'h0010, 16'h0020);
      drain();
      check("b2b_interval", acc_cyc[i0+1] - acc_cyc[i0], LAT + 2);
      check("b2b_last_y", rsp_y, 17'h00030);
      check("b2b_count", op_count, 16'(n0 + 2));

      // reset while waiting on the ALU
      send(3'd0, 16'h0001, 16'h0002);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midwait_ready", cmd_ready, 1'b1);
      saw_valid = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (rsp_valid) saw_valid = 1;
      end
      check("midwait_no_rsp", saw_valid, 1'b0);
      check("midwait_count", op_count, 16'd0);

      // op_count wrap
      force dut.op_count = 16'hFFFF;
      #1;
      release dut.op_count;
      m_count = 16'hFFFF;
      send(3'd4, 16'h00AA, 16'h0000);
      drain();
      check("wrap_count", op_count, 16'h0000);

      // randomized traffic with occasional reset
      for (int k = 0; k < 500; k++) begin
         rst = ($urandom_range(0, 59) == 0);
         if (!cmd_valid || !m_busy) begin
            cmd_valid = $urandom_range(0, 1);
            cmd_op = 3'($urandom);
            cmd_a  = 16'($urandom);
            cmd_b  = 16'($urandom);
         end
         rsp_ready = ($urandom_range(0, 2) != 0);
         tick();
      end
      rst = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b1;
      drain();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
